// File: rtl/control_unit.sv
// Microcoded-style control FSM for a single-bus datapath: fetch/decode plus
// ALU, LOAD, PUSH, POP, JMP/BRZ and HALT, with a bounded memory-wait timeout.
module control_unit #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] instruction,
  input  logic        status,
  input  logic        mem_ready,
  output logic        ld_reg,
  output logic        t_reg,
  output logic        ld_ir,
  output logic        t_ir,
  output logic        ld_mar,
  output logic        t_mar,
  output logic        ld_mdr,
  output logic        t_mdr,
  output logic        ld_sp,
  output logic        t_sp,
  output logic        ld_pc,
  output logic        t_pc,
  output logic        ld_y,
  output logic        t_y,
  output logic        selector,
  output logic [1:0]  controller_fn,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic        halted,
  output logic        mem_err,
  output logic [4:0]  state_o
);

  localparam int CW = ($clog2(MEM_TIMEOUT + 1) > 4) ? $clog2(MEM_TIMEOUT + 1) : 4;
  localparam logic [CW-1:0] TMO_LAST = CW'(MEM_TIMEOUT - 1);

  localparam logic [1:0] FN_PASS = 2'b00;
  localparam logic [1:0] FN_INC  = 2'b01;
  localparam logic [1:0] FN_DEC  = 2'b10;

  typedef enum logic [4:0] {
    S_IDLE, S_F0, S_F1, S_F2, S_F3, S_DECODE, S_A0, S_A1,
    S_L0, S_L1, S_L2, S_P0, S_P1, S_P2, S_Q0, S_Q1, S_Q2, S_Q3,
    S_JMP, S_HALT, S_ERR
  } state_t;

  state_t        state_q, state_d, wait_next;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          is_wait;
  logic          unused_ir;

  assign unused_ir = ^instruction[11:0];
  assign state_o   = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = '0;
    is_wait       = 1'b0;
    wait_next     = S_F0;
    ld_reg        = 1'b0;
    t_reg         = 1'b0;
    ld_ir         = 1'b0;
    t_ir          = 1'b0;
    ld_mar        = 1'b0;
    t_mar         = 1'b0;
    ld_mdr        = 1'b0;
    t_mdr         = 1'b0;
    ld_sp         = 1'b0;
    t_sp          = 1'b0;
    ld_pc         = 1'b0;
    t_pc          = 1'b0;
    ld_y          = 1'b0;
    t_y           = 1'b0;
    selector      = 1'b1;
    controller_fn = FN_PASS;
    mem_rd        = 1'b0;
    mem_wr        = 1'b0;
    halted        = 1'b0;
    mem_err       = 1'b0;

    case (state_q)
      S_IDLE: begin
        selector = 1'b0;
        state_d  = S_F0;
      end
      S_F0: begin t_pc = 1'b1; ld_mar = 1'b1; state_d = S_F1; end
      S_F1: begin mem_rd = 1'b1; ld_mdr = mem_ready; is_wait = 1'b1; wait_next = S_F2; end
      S_F2: begin t_mdr = 1'b1; ld_ir = 1'b1; state_d = S_F3; end
      S_F3: begin t_pc = 1'b1; controller_fn = FN_INC; ld_pc = 1'b1; state_d = S_DECODE; end
      S_DECODE: begin
        case (instruction[15:12])
          4'b0001: state_d = S_A0;
          4'b0010: state_d = S_L0;
          4'b0011: state_d = S_P0;
          4'b0100: state_d = S_JMP;
          4'b0101: state_d = status ? S_JMP : S_F0;
          4'b0110: state_d = S_Q0;
          4'b1111: state_d = S_HALT;
          default: state_d = S_F0;
        endcase
      end
      S_A0: begin t_reg = 1'b1; ld_y = 1'b1; state_d = S_A1; end
      S_A1: begin t_reg = 1'b1; selector = 1'b0; ld_reg = 1'b1; state_d = S_F0; end
      S_L0: begin t_reg = 1'b1; ld_mar = 1'b1; state_d = S_L1; end
      S_L1: begin mem_rd = 1'b1; ld_mdr = mem_ready; is_wait = 1'b1; wait_next = S_L2; end
      S_L2: begin t_mdr = 1'b1; ld_reg = 1'b1; state_d = S_F0; end
      S_P0: begin t_sp = 1'b1; controller_fn = FN_DEC; ld_sp = 1'b1; state_d = S_P1; end
      S_P1: begin t_sp = 1'b1; ld_mar = 1'b1; state_d = S_P2; end
      S_P2: begin t_reg = 1'b1; mem_wr = 1'b1; is_wait = 1'b1; wait_next = S_F0; end
      S_Q0: begin t_sp = 1'b1; ld_mar = 1'b1; state_d = S_Q1; end
      S_Q1: begin mem_rd = 1'b1; ld_mdr = mem_ready; is_wait = 1'b1; wait_next = S_Q2; end
      S_Q2: begin t_mdr = 1'b1; ld_reg = 1'b1; state_d = S_Q3; end
      S_Q3: begin t_sp = 1'b1; controller_fn = FN_INC; ld_sp = 1'b1; state_d = S_F0; end
      S_JMP: begin t_reg = 1'b1; ld_pc = 1'b1; state_d = S_F0; end
      S_HALT: halted = 1'b1;
      S_ERR: begin halted = 1'b1; mem_err = 1'b1; end
      default: state_d = S_IDLE;
    endcase

    // Shared memory-wait handling: the counter only lives inside a wait state,
    // so it reads zero on every entry without an explicit clear.
    if (is_wait) begin
      if (mem_ready) begin
        state_d = wait_next;
      end else if (cnt_q == TMO_LAST) begin
        state_d = S_ERR;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: the driver pushes the expected output
// vector for every cycle it drives; a negedge monitor pops and compares.
module tb_control_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] instruction = 16'h0000;
  logic        status = 1'b0;
  logic        mem_ready = 1'b0;
  logic ld_reg, t_reg, ld_ir, t_ir, ld_mar, t_mar, ld_mdr, t_mdr;
  logic ld_sp, t_sp, ld_pc, t_pc, ld_y, t_y, selector;
  logic [1:0] controller_fn;
  logic mem_rd, mem_wr, halted, mem_err;
  logic [4:0] state_o;

  control_unit #(.MEM_TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n), .instruction(instruction), .status(status),
    .mem_ready(mem_ready),
    .ld_reg(ld_reg), .t_reg(t_reg), .ld_ir(ld_ir), .t_ir(t_ir),
    .ld_mar(ld_mar), .t_mar(t_mar), .ld_mdr(ld_mdr), .t_mdr(t_mdr),
    .ld_sp(ld_sp), .t_sp(t_sp), .ld_pc(ld_pc), .t_pc(t_pc),
    .ld_y(ld_y), .t_y(t_y), .selector(selector), .controller_fn(controller_fn),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .halted(halted), .mem_err(mem_err),
    .state_o(state_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  // Output vector layout (bit 20 down to 0)
  localparam logic [20:0] LD_REG = 21'(1) << 20, T_REG = 21'(1) << 19;
  localparam logic [20:0] LD_IR  = 21'(1) << 18;
  localparam logic [20:0] LD_MAR = 21'(1) << 16;
  localparam logic [20:0] LD_MDR = 21'(1) << 14, T_MDR = 21'(1) << 13;
  localparam logic [20:0] LD_SP  = 21'(1) << 12, T_SP  = 21'(1) << 11;
  localparam logic [20:0] LD_PC  = 21'(1) << 10, T_PC  = 21'(1) << 9;
  localparam logic [20:0] LD_Y   = 21'(1) << 8;
  localparam logic [20:0] SEL    = 21'(1) << 6;
  localparam logic [20:0] F_INC  = 21'(1) << 4, F_DEC = 21'(2) << 4;
  localparam logic [20:0] MRD    = 21'(1) << 3, MWR = 21'(1) << 2;
  localparam logic [20:0] HLT    = 21'(1) << 1, MERR = 21'(1);

  localparam logic [20:0] E_IDLE = 21'(0);
  localparam logic [20:0] E_F0   = T_PC | LD_MAR | SEL;
  localparam logic [20:0] E_RDW  = MRD | SEL;
  localparam logic [20:0] E_RDOK = MRD | LD_MDR | SEL;
  localparam logic [20:0] E_F2   = T_MDR | LD_IR | SEL;
  localparam logic [20:0] E_F3   = T_PC | LD_PC | F_INC | SEL;
  localparam logic [20:0] E_DEC  = SEL;
  localparam logic [20:0] E_A0   = T_REG | LD_Y | SEL;
  localparam logic [20:0] E_A1   = T_REG | LD_REG;
  localparam logic [20:0] E_JMP  = T_REG | LD_PC | SEL;
  localparam logic [20:0] E_L0   = T_REG | LD_MAR | SEL;
  localparam logic [20:0] E_MDR2REG = T_MDR | LD_REG | SEL;
  localparam logic [20:0] E_P0   = T_SP | LD_SP | F_DEC | SEL;
  localparam logic [20:0] E_SPMAR = T_SP | LD_MAR | SEL;
  localparam logic [20:0] E_P2   = T_REG | MWR | SEL;
  localparam logic [20:0] E_Q3   = T_SP | LD_SP | F_INC | SEL;
  localparam logic [20:0] E_HALT = HLT | SEL;
  localparam logic [20:0] E_ERR  = HLT | MERR | SEL;

  logic [20:0] act;
  assign act = {ld_reg, t_reg, ld_ir, t_ir, ld_mar, t_mar, ld_mdr, t_mdr,
                ld_sp, t_sp, ld_pc, t_pc, ld_y, t_y, selector, controller_fn,
                mem_rd, mem_wr, halted, mem_err};

  // scoreboard
  logic [20:0] exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (exp_q.size() > 0) begin
      logic [20:0] e;
      e = exp_q.pop_front();
      checks++;
      if (act !== e) begin
        errors++;
        $display("FAIL outputs cyc=%0d state=%0d actual=%h required=%h", cyc, state_o, act, e);
      end
      checks++;
      if ($countones({t_reg, t_ir, t_mar, t_mdr, t_sp, t_pc, t_y}) > 1) begin
        errors++;
        $display("FAIL one_hot_t cyc=%0d actual=%b required=at most one high", cyc,
                 {t_reg, t_ir, t_mar, t_mdr, t_sp, t_pc, t_y});
      end
    end
  end

  // driver tasks: entered and left at posedge+1
  task automatic step(input logic [20:0] e, input logic [15:0] ins,
                      input logic st, input logic rdy);
    instruction = ins;
    status      = st;
    mem_ready   = rdy;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [15:0] ins, input logic st, input int nwait);
    step(E_F0, ins, st, 1'b1);
    for (int i = 0; i < nwait; i++) step(E_RDW, ins, st, 1'b0);
    step(E_RDOK, ins, st, 1'b1);
    step(E_F2, ins, st, 1'b1);
    step(E_F3, ins, st, 1'b1);
    step(E_DEC, ins, st, 1'b1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(E_IDLE, 16'h0000, 1'b0, 1'b1);
    rst_n = 1'b1;
    step(E_IDLE, 16'h0000, 1'b0, 1'b1);
  endtask

  initial begin
    @(posedge clk);
    #1;
    step(E_IDLE, 16'h0000, 1'b0, 1'b1);
    do_reset();

    // NOP loop, 5 cycles per instruction
    fetch(16'h0000, 1'b0, 0);
    fetch(16'h0000, 1'b1, 0);
    // ALU op
    fetch(16'h1310, 1'b0, 0);
    step(E_A0, 16'h1310, 1'b0, 1'b1);
    step(E_A1, 16'h1310, 1'b0, 1'b1);
    // conditional branch not taken, then taken; unconditional jump
    fetch(16'h5000, 1'b0, 0);
    fetch(16'h5000, 1'b1, 0);
    step(E_JMP, 16'h5000, 1'b0, 1'b1);
    fetch(16'h4abc, 1'b0, 0);
    step(E_JMP, 16'h4abc, 1'b0, 1'b1);
    // unlisted opcodes fall back to fetch
    fetch(16'h7fff, 1'b1, 0);
    fetch(16'he123, 1'b0, 0);
    // LOAD with a two-cycle wait
    fetch(16'h2000, 1'b0, 0);
    step(E_L0, 16'h2000, 1'b0, 1'b1);
    step(E_RDW, 16'h2000, 1'b0, 1'b0);
    step(E_RDW, 16'h2000, 1'b0, 1'b0);
    step(E_RDOK, 16'h2000, 1'b0, 1'b1);
    step(E_MDR2REG, 16'h2000, 1'b0, 1'b1);
    // POP with a one-cycle wait
    fetch(16'h6000, 1'b0, 0);
    step(E_SPMAR, 16'h6000, 1'b0, 1'b0);
    step(E_RDW, 16'h6000, 1'b0, 1'b0);
    step(E_RDOK, 16'h6000, 1'b0, 1'b1);
    step(E_MDR2REG, 16'h6000, 1'b0, 1'b1);
    step(E_Q3, 16'h6000, 1'b0, 1'b1);
    // fetch with 3 wait cycles, and with 14 (last cycle before timeout)
    fetch(16'h0000, 1'b0, 3);
    fetch(16'h0000, 1'b0, 14);
    // PUSH with a two-cycle write wait
    fetch(16'h3000, 1'b0, 0);
    step(E_P0, 16'h3000, 1'b0, 1'b0);
    step(E_SPMAR, 16'h3000, 1'b0, 1'b0);
    step(E_P2, 16'h3000, 1'b0, 1'b0);
    step(E_P2, 16'h3000, 1'b0, 1'b0);
    step(E_P2, 16'h3000, 1'b0, 1'b1);
    // read timeout: 15 wait cycles then ERR, absorbing
    step(E_F0, 16'h0000, 1'b0, 1'b0);
    for (int i = 0; i < 15; i++) step(E_RDW, 16'h0000, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) step(E_ERR, 16'hf000, 1'b1, 1'($urandom_range(0, 1)));
    do_reset();
    // PUSH interrupted by an async reset mid-write
    fetch(16'h3000, 1'b0, 0);
    step(E_P0, 16'h3000, 1'b0, 1'b0);
    step(E_SPMAR, 16'h3000, 1'b0, 1'b0);
    step(E_P2, 16'h3000, 1'b0, 1'b0);
    instruction = 16'h3000;
    mem_ready   = 1'b0;
    exp_q.push_back(E_IDLE);
    #2 rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(E_IDLE, 16'h0000, 1'b0, 1'b1);
    // HALT absorbing for 100 cycles
    fetch(16'hf000, 1'b0, 0);
    for (int i = 0; i < 100; i++)
      step(E_HALT, 16'($urandom_range(0, 65535)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)));

    repeat (2) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain actual=%0d required=0 pending", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=completion");
    $fatal(1, "watchdog expired");
  end

endmodule
